// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin scheduler sharing one pipelined 16x16 multiplier
// between two requesters. Accepted operand pairs are tagged with the
// requester ID in an in-order tag FIFO, and each returning result is routed to
// the requester that issued it. Provides enable/drain control, an idle flag
// and a sticky error for results that arrive with no outstanding tag.
module mult_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TAGDEPTH = 16,
    parameter int unsigned LOGTAG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sched_en,
    input  logic              req0_valid,
    input  logic [15:0]       req0_a,
    input  logic [15:0]       req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [15:0]       req1_a,
    input  logic [15:0]       req1_b,
    output logic              req1_ready,
    output logic              mul_valid,
    output logic [15:0]       mul_a,
    output logic [15:0]       mul_b,
    input  logic              mul_ready,
    input  logic              res_valid,
    input  logic [WIDTH-1:0]  res_data,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [LOGTAG:0]   outstanding,
    output logic              idle,
    output logic              err_orphan
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [LOGTAG:0]     count_q, count_d;
    logic [LOGTAG-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOGTAG-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TAGDEPTH-1:0] tag_q, tag_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                err_orphan_q, err_orphan_d;

    logic fifo_full;
    logic fifo_empty;
    logic can_issue;
    logic grant;
    logic grant_id;
    logic push;
    logic pop;
    logic head_tag;

    // Issue arbitration: round-robin grant and combinational operand mux
    always_comb begin
        fifo_full  = (count_q == (LOGTAG+1)'(TAGDEPTH));
        fifo_empty = (count_q == '0);
        // A full FIFO may still accept a push when a result pops a tag this cycle.
        can_issue  = (state_q == S_RUN) && mul_ready && (!fifo_full || res_valid);
        grant_id   = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        grant      = can_issue && (req0_valid || req1_valid);
        push       = grant;
        pop        = res_valid && !fifo_empty;
        head_tag   = tag_q[rd_ptr_q];

        req0_ready = grant && !grant_id;
        req1_ready = grant && grant_id;
        mul_valid  = grant;
        mul_a      = '0;
        mul_b      = '0;
        if (grant) begin
            mul_a = grant_id ? req1_a : req0_a;
            mul_b = grant_id ? req1_b : req0_b;
        end
    end

    // Tag FIFO, grant history, response routing and orphan detection
    always_comb begin
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;

        if (push) begin
            tag_d[wr_ptr_q] = grant_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            last_grant_d    = grant_id;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        rsp0_valid_d = pop && !head_tag;
        rsp1_valid_d = pop && head_tag;
        rsp_data_d   = pop ? res_data : rsp_data_q;
        err_orphan_d = err_orphan_q || (res_valid && fifo_empty);
    end

    // FSM next state: RUN grants, DRAIN waits for outstanding results
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sched_en) state_d = S_RUN;
            end
            S_RUN: begin
                if (!sched_en) begin
                    state_d = (fifo_empty && !push && !pop) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (sched_en)            state_d = S_RUN;
                else if (count_d == '0)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; requester 0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_q        <= tag_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_data_q   <= rsp_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp_data    = rsp_data_q;
    assign outstanding = count_q;
    assign idle        = (state_q == S_IDLE);
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: the bench plays the multiplier (fixed-latency
// result queue) and checks every cycle against a queue-based reference model.
module tb_mult_arbiter;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned TAGDEPTH = 16;
    localparam int unsigned LOGTAG   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sched_en;
    logic              req0_valid, req1_valid;
    logic [15:0]       req0_a, req0_b, req1_a, req1_b;
    logic              req0_ready, req1_ready;
    logic              mul_valid, mul_ready;
    logic [15:0]       mul_a, mul_b;
    logic              res_valid;
    logic [WIDTH-1:0]  res_data;
    logic              rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0]  rsp_data;
    logic [LOGTAG:0]   outstanding;
    logic              idle, err_orphan;

    always #5 clk = ~clk;

    mult_arbiter #(
        .WIDTH    (WIDTH),
        .TAGDEPTH (TAGDEPTH),
        .LOGTAG   (LOGTAG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sched_en    (sched_en),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .mul_valid   (mul_valid),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .rsp0_valid  (rsp0_valid),
        .rsp1_valid  (rsp1_valid),
        .rsp_data    (rsp_data),
        .outstanding (outstanding),
        .idle        (idle),
        .err_orphan  (err_orphan)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    typedef struct {
        logic [WIDTH-1:0] p;
        int               due;
    } mres_t;

    int               m_mode = M_IDLE;
    bit               m_last = 1'b1;
    int               tagq[$];
    bit               m_rsp0, m_rsp1, m_err;
    logic [WIDTH-1:0] m_rspd = '0;
    mres_t            mulq[$];

    int cyc  = 0;
    int lat  = 3;
    bit hold = 1'b0;
    bit inj  = 1'b0;
    bit s_grant, s_g1;

    // One clock cycle: drive the multiplier result, check, advance the model
    task automatic step();
        bit    can, grant, pop, from_q;
        int    sz, gid, t;
        mres_t r;
        @(negedge clk);
        from_q    = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        if (!hold && mulq.size() > 0 && mulq[0].due <= cyc) begin
            res_valid = 1'b1;
            res_data  = mulq[0].p;
            from_q    = 1'b1;
        end else if (inj && mulq.size() == 0) begin
            res_valid = 1'b1;
            res_data  = WIDTH'($urandom);
        end
        #1;
        sz    = tagq.size();
        can   = (m_mode == M_RUN) && mul_ready && (sz < int'(TAGDEPTH) || res_valid);
        grant = can && (req0_valid || req1_valid);
        gid   = (req0_valid && req1_valid) ? (m_last ? 0 : 1) : (req1_valid ? 1 : 0);

        check_eq("req0_ready", req0_ready, grant && gid == 0);
        check_eq("req1_ready", req1_ready, grant && gid == 1);
        check_eq("mul_valid",  mul_valid,  grant);
        check_eq("mul_a", mul_a, grant ? (gid == 1 ? req1_a : req0_a) : 16'h0);
        check_eq("mul_b", mul_b, grant ? (gid == 1 ? req1_b : req0_b) : 16'h0);
        check_eq("rsp0_valid", rsp0_valid, m_rsp0);
        check_eq("rsp1_valid", rsp1_valid, m_rsp1);
        check_eq("rsp_data", rsp_data, m_rspd);
        check_eq("outstanding", outstanding, sz);
        check_eq("idle", idle, m_mode == M_IDLE);
        check_eq("err_orphan", err_orphan, m_err);

        s_grant = req0_ready | req1_ready;
        s_g1    = req1_ready;

        if (from_q) mulq.delete(0);
        pop = res_valid && sz > 0;
        if (pop) begin
            t      = tagq.pop_front();
            m_rsp0 = (t == 0);
            m_rsp1 = (t == 1);
            m_rspd = res_data;
        end else begin
            m_rsp0 = 1'b0;
            m_rsp1 = 1'b0;
        end
        if (res_valid && sz == 0) m_err = 1'b1;
        if (grant) begin
            tagq.push_back(gid);
            m_last = (gid == 1);
            r.p    = (gid == 1) ? ({16'h0, req1_a} * {16'h0, req1_b})
                                : ({16'h0, req0_a} * {16'h0, req0_b});
            r.due  = cyc + lat;
            mulq.push_back(r);
        end
        case (m_mode)
            M_IDLE:  if (sched_en) m_mode = M_RUN;
            M_RUN:   if (!sched_en) m_mode = (sz == 0 && !grant && !pop) ? M_IDLE : M_DRAIN;
            default: begin
                if (sched_en)              m_mode = M_RUN;
                else if (tagq.size() == 0) m_mode = M_IDLE;
            end
        endcase
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must clear immediately
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        tagq.delete();
        m_mode = M_IDLE;
        m_last = 1'b1;
        m_rsp0 = 1'b0;
        m_rsp1 = 1'b0;
        m_rspd = '0;
        m_err  = 1'b0;
        check_eq("rst_req0_ready", req0_ready, 0);
        check_eq("rst_req1_ready", req1_ready, 0);
        check_eq("rst_mul_valid", mul_valid, 0);
        check_eq("rst_mul_a", mul_a, 0);
        check_eq("rst_mul_b", mul_b, 0);
        check_eq("rst_rsp0_valid", rsp0_valid, 0);
        check_eq("rst_rsp1_valid", rsp1_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_err_orphan", err_orphan, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev, got0, got1, done;
        int t0, t1;

        rst        = 1'b1;
        sched_en   = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a     = 16'h1234;
        req0_b     = 16'h5678;
        req1_a     = 16'h9abc;
        req1_b     = 16'hdef0;
        mul_ready  = 1'b1;
        res_valid  = 1'b0;
        res_data   = '0;
        do_reset();

        // Alternating grants, requester 0 first
        sched_en = 1'b1;
        step();
        check_eq("first_cycle_no_grant", s_grant, 0);
        for (int i = 0; i < 8; i++) begin
            req0_a = 16'($urandom); req0_b = 16'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom);
            step();
            check_eq("alt_grant", s_grant, 1);
            check_eq("alt_id", s_g1, (i % 2) == 1);
        end

        // Multiplier stall keeps the round-robin pointer
        prev      = s_g1;
        mul_ready = 1'b0;
        repeat (5) begin
            step();
            check_eq("stall_no_grant", s_grant, 0);
        end
        mul_ready = 1'b1;
        step();
        check_eq("stall_tie_winner", s_g1, !prev);

        // Directed products with latency 9
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (8) step();
        lat        = 9;
        req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd4;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd5; req1_b = 16'd6;
        step();
        req1_valid = 1'b0;
        got0 = 1'b0; got1 = 1'b0; t0 = 0; t1 = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp0_valid && !got0) begin
                got0 = 1'b1; t0 = i;
                check_eq("rsp0_data_3x4", rsp_data, 12);
            end
            if (rsp1_valid && !got1) begin
                got1 = 1'b1; t1 = i;
                check_eq("rsp1_data_5x6", rsp_data, 30);
            end
        end
        check_eq("rsp0_seen", got0, 1);
        check_eq("rsp1_seen", got1, 1);
        check_eq("rsp_order", t1 == t0 + 1, 1);

        // Fill the tag FIFO, then push while popping at full
        lat        = 3;
        hold       = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (16) step();
        check_eq("full_outstanding", outstanding, 16);
        step();
        check_eq("full_no_grant", s_grant, 0);
        hold = 1'b0;
        step();
        check_eq("full_swap_grant", s_grant, 1);
        check_eq("full_swap_outstanding", outstanding, 16);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (24) step();
        check_eq("full_drained", outstanding, 0);

        // Drain with 4 outstanding
        hold       = 1'b1;
        req0_valid = 1'b1;
        repeat (4) step();
        check_eq("drain_outstanding", outstanding, 4);
        sched_en   = 1'b0;
        req0_valid = 1'b0;
        step();
        check_eq("drain_not_idle", idle, 0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) begin
            step();
            check_eq("drain_no_grant", s_grant, 0);
        end
        hold       = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        done       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (idle) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("drain_idle", done, 1);
        check_eq("drain_empty", outstanding, 0);

        // Orphan result
        inj = 1'b1;
        step();
        inj = 1'b0;
        check_eq("orphan_err", err_orphan, 1);
        check_eq("orphan_no_rsp0", rsp0_valid, 0);
        check_eq("orphan_no_rsp1", rsp1_valid, 0);
        repeat (3) step();
        check_eq("orphan_sticky", err_orphan, 1);

        // Randomized traffic with a mid-stream reset
        do_reset();
        for (int i = 0; i < 800; i++) begin
            sched_en   = ($urandom_range(0, 19) != 0);
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_a     = 16'($urandom); req0_b = 16'($urandom);
            req1_a     = 16'($urandom); req1_b = 16'($urandom);
            mul_ready  = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) hold = !hold;
            inj        = ($urandom_range(0, 19) == 0);
            step();
            if (i == 400) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
